// File: rtl/kyber_pkg.sv
// Shared types and helpers for the Baby-Kyber key generator.
package kyber_pkg;

  typedef enum logic [1:0] {
    KIND_A = 2'd0,
    KIND_T = 2'd1,
    KIND_S = 2'd2
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMP_A,
    ST_SAMP_S,
    ST_SAMP_E,
    ST_MUL,
    ST_STREAM,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  // Reduce a signed accumulator into [0, q-1]; negative residues are lifted by q.
  function automatic logic [15:0] mod_q(input logic signed [63:0] acc, input logic [15:0] q);
    logic signed [63:0] qs;
    logic signed [63:0] r;
    qs = $signed({48'd0, q});
    r  = acc % qs;
    if (r < 0) r = r + qs;
    return r[15:0];
  endfunction

endpackage

// File: rtl/kyber_sampler.sv
// 32-bit Galois LFSR with a rejection comparator: one step per draw, the low
// CW bits of the stepped state are offered as r and accepted when r < bound.
module kyber_sampler
  import kyber_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [31:0]   seed,
  input  logic          draw,
  input  logic [CW:0]   bound,
  output logic [CW-1:0] r,
  output logic          accept
);

  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_step;

  // Right-shifting Galois step; the mask is folded in when the bit shifted out is set.
  always_comb begin
    lfsr_step = lfsr_reg >> 1;
    if (lfsr_reg[0]) lfsr_step = (lfsr_reg >> 1) ^ LFSR_MASK;
  end

  assign r      = lfsr_step[CW-1:0];
  assign accept = ({1'b0, r} < bound);

  // State register: a zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= '0;
    end else if (load) begin
      lfsr_reg <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (draw) begin
      lfsr_reg <= lfsr_step;
    end
  end

endmodule

// File: rtl/kyber_keygen_seq.sv
// Sequential Baby-Kyber key generator: samples A, s, e, computes t = A*s + e
// in Z_Q[x]/(x^N+1) with one shared MAC, then streams A, t, s.
module kyber_keygen_seq
  import kyber_pkg::*;
#(
  parameter int K   = 2,
  parameter int N   = 4,
  parameter int Q   = 17,
  parameter int ETA = 1,
  localparam int CW = $clog2(Q)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_kind,
  output logic [15:0]   out_idx,
  output logic [CW:0]   out_coef
);

  localparam int NA   = K * K * N;
  localparam int NV   = K * N;
  localparam int NLW  = $clog2(N);
  localparam int VIW  = $clog2(NV);
  localparam int AIW  = $clog2(NA);
  localparam int ACCW = 2 * CW + 2 + $clog2(NV);
  localparam logic [15:0] NA_L = 16'(NA);
  localparam logic [15:0] NV_L = 16'(NV);
  localparam logic [15:0] NB_L = 16'(NA + 2 * NV);
  localparam logic [CW:0] BOUND_A  = (CW + 1)'(Q);
  localparam logic [CW:0] BOUND_SE = (CW + 1)'(2 * ETA + 1);
  localparam logic signed [CW:0] ETA_S = (CW + 1)'(ETA);

  state_e state_reg, state_next;
  logic [15:0] cnt_reg;        // sample index, then stream beat index
  logic [15:0] out_cnt_reg;    // flat (i,k) of the t coefficient being built
  logic [15:0] prod_cnt_reg;   // flat (j,m) product index; NV means "finalise"
  logic signed [ACCW-1:0] acc_reg;

  logic [CW-1:0]      a_mem [NA];
  logic signed [CW:0] s_mem [NV];
  logic signed [CW:0] e_mem [NV];
  logic [CW-1:0]      t_mem [NV];

  logic          samp_load, samp_draw, samp_accept;
  logic [CW:0]   samp_bound;
  logic [CW-1:0] samp_r;
  logic signed [CW:0] sample_coef;

  logic [NLW-1:0] m_idx, k_idx;
  logic [VIW-1:0] s_addr;
  logic [15:0]    a_addr;
  logic signed [CW:0]       a_val, s_val;
  logic signed [2*CW+1:0]   mult;
  logic signed [ACCW-1:0]   prod_term, acc_sum;
  logic [15:0]    t_val;
  logic [15:0]    beat_off;

  assign samp_load  = (state_reg == ST_IDLE) && start;
  assign samp_draw  = (state_reg == ST_SAMP_A) || (state_reg == ST_SAMP_S) || (state_reg == ST_SAMP_E);
  assign samp_bound = (state_reg == ST_SAMP_A) ? BOUND_A : BOUND_SE;
  assign sample_coef = $signed({1'b0, samp_r}) - ETA_S;

  kyber_sampler #(.CW(CW)) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (samp_load),
    .seed   (seed),
    .draw   (samp_draw),
    .bound  (samp_bound),
    .r      (samp_r),
    .accept (samp_accept)
  );

  // MAC operands: A[i][j][m] * s[j][(k-m) mod N], negated when the product wraps past x^N.
  assign m_idx     = prod_cnt_reg[NLW-1:0];
  assign k_idx     = out_cnt_reg[NLW-1:0];
  assign s_addr    = {prod_cnt_reg[VIW-1:NLW], k_idx - m_idx};
  assign a_addr    = 16'(out_cnt_reg[VIW-1:NLW]) * NV_L + prod_cnt_reg;
  assign a_val     = $signed({1'b0, a_mem[a_addr[AIW-1:0]]});
  assign s_val     = s_mem[s_addr];
  assign mult      = a_val * s_val;
  assign prod_term = (m_idx <= k_idx) ? ACCW'(mult) : -ACCW'(mult);
  assign acc_sum   = acc_reg + ACCW'(e_mem[out_cnt_reg[VIW-1:0]]);
  assign t_val     = mod_q(64'(acc_sum), 16'(Q));

  // Next-state logic plus status and stream outputs decoded from the beat counter.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    out_kind   = 2'd0;
    out_idx    = 16'd0;
    out_coef   = '0;
    beat_off   = 16'd0;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_SAMP_A;
      ST_SAMP_A: if (samp_accept && cnt_reg == NA_L - 16'd1) state_next = ST_SAMP_S;
      ST_SAMP_S: if (samp_accept && cnt_reg == NV_L - 16'd1) state_next = ST_SAMP_E;
      ST_SAMP_E: if (samp_accept && cnt_reg == NV_L - 16'd1) state_next = ST_MUL;
      ST_MUL:    if (prod_cnt_reg == NV_L && out_cnt_reg == NV_L - 16'd1) state_next = ST_STREAM;
      ST_STREAM: if (out_ready && cnt_reg == NB_L - 16'd1) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (state_reg != ST_IDLE && state_reg != ST_DONE) busy = 1'b1;
    if (state_reg == ST_DONE) done = 1'b1;
    if (state_reg == ST_STREAM) begin
      out_valid = 1'b1;
      if (cnt_reg < NA_L) begin
        out_kind = KIND_A;
        out_idx  = cnt_reg;
        out_coef = {1'b0, a_mem[cnt_reg[AIW-1:0]]};
      end else if (cnt_reg < NA_L + NV_L) begin
        beat_off = cnt_reg - NA_L;
        out_kind = KIND_T;
        out_idx  = beat_off;
        out_coef = {1'b0, t_mem[beat_off[VIW-1:0]]};
      end else begin
        beat_off = cnt_reg - NA_L - NV_L;
        out_kind = KIND_S;
        out_idx  = beat_off;
        out_coef = s_mem[beat_off[VIW-1:0]];
      end
    end
  end

  // State, counters, MAC accumulator and key storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      out_cnt_reg  <= '0;
      prod_cnt_reg <= '0;
      acc_reg      <= '0;
      for (int x = 0; x < NA; x++) a_mem[x] <= '0;
      for (int x = 0; x < NV; x++) begin
        s_mem[x] <= '0;
        e_mem[x] <= '0;
        t_mem[x] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg      <= '0;
          out_cnt_reg  <= '0;
          prod_cnt_reg <= '0;
          acc_reg      <= '0;
        end
        ST_SAMP_A: if (samp_accept) begin
          a_mem[cnt_reg[AIW-1:0]] <= samp_r;
          cnt_reg <= (cnt_reg == NA_L - 16'd1) ? 16'd0 : cnt_reg + 16'd1;
        end
        ST_SAMP_S: if (samp_accept) begin
          s_mem[cnt_reg[VIW-1:0]] <= sample_coef;
          cnt_reg <= (cnt_reg == NV_L - 16'd1) ? 16'd0 : cnt_reg + 16'd1;
        end
        ST_SAMP_E: if (samp_accept) begin
          e_mem[cnt_reg[VIW-1:0]] <= sample_coef;
          cnt_reg <= (cnt_reg == NV_L - 16'd1) ? 16'd0 : cnt_reg + 16'd1;
        end
        ST_MUL: begin
          if (prod_cnt_reg < NV_L) begin
            acc_reg      <= acc_reg + prod_term;
            prod_cnt_reg <= prod_cnt_reg + 16'd1;
          end else begin
            t_mem[out_cnt_reg[VIW-1:0]] <= t_val[CW-1:0];
            acc_reg      <= '0;
            prod_cnt_reg <= '0;
            out_cnt_reg  <= out_cnt_reg + 16'd1;
          end
        end
        ST_STREAM: if (out_ready) cnt_reg <= cnt_reg + 16'd1;
        ST_DONE:   cnt_reg <= '0;
        default:   cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_keygen_seq.sv
// Self-checking bench: a polynomial-level key generation model predicts every
// streamed beat; one monitor compares DUT beats against it each handshake.
module tb_kyber_keygen_seq;

  localparam logic [31:0] MASK = 32'h80200003;

  typedef struct {
    int kind;
    int idx;
    int coef;
  } beat_t;
  typedef int int_da[];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [31:0] seed0, seed1;
  logic        out_ready0;
  logic        out_ready1;
  logic        busy0, done0, valid0;
  logic        busy1, done1, valid1;
  logic [1:0]  kind0, kind1;
  logic [15:0] idx0, idx1;
  logic [5:0]  coef0;
  logic [12:0] coef1;

  kyber_keygen_seq #(.K(2), .N(4), .Q(17), .ETA(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0),
    .busy(busy0), .done(done0), .out_valid(valid0), .out_ready(out_ready0),
    .out_kind(kind0), .out_idx(idx0), .out_coef(coef0)
  );

  kyber_keygen_seq #(.K(3), .N(8), .Q(3329), .ETA(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
    .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(out_ready1),
    .out_kind(kind1), .out_idx(idx1), .out_coef(coef1)
  );

  int checks = 0;
  int failures = 0;
  beat_t model_q[$];
  int model_draws;
  beat_t exp0[$];
  beat_t exp1[$];
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  bit bp_mode = 1'b0;

  task automatic check_eq(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clog2i(input int v);
    int w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

  // Coefficient d of a*b in Z[x]/(x^n+1): degree-(d+n) terms fold back negated.
  function automatic int nc_coef(input int_da a, input int_da b, input int n, input int d);
    int acc = 0;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++) begin
        if (x + y == d) acc += a[x] * b[y];
        else if (x + y == d + n) acc -= a[x] * b[y];
      end
    return acc;
  endfunction

  // Full key generation from the seed, producing the expected beat list.
  task automatic build_model(input int k, input int n, input int q, input int eta, input logic [31:0] seed);
    logic [31:0] st;
    int cw, r, acc;
    int_da av, sv, ev, pa, ps;
    beat_t b;
    av = new[k * k * n];
    sv = new[k * n];
    ev = new[k * n];
    pa = new[n];
    ps = new[n];
    model_q.delete();
    model_draws = 0;
    cw = clog2i(q);
    st = (seed == 32'd0) ? 32'd1 : seed;
    for (int x = 0; x < k * k * n; x++) begin
      do begin
        st = st[0] ? ((st >> 1) ^ MASK) : (st >> 1);
        model_draws++;
        r = int'(st & ((32'd1 << cw) - 32'd1));
      end while (r >= q);
      av[x] = r;
    end
    for (int x = 0; x < 2 * k * n; x++) begin
      do begin
        st = st[0] ? ((st >> 1) ^ MASK) : (st >> 1);
        model_draws++;
        r = int'(st & ((32'd1 << cw) - 32'd1));
      end while (r >= 2 * eta + 1);
      if (x < k * n) sv[x] = r - eta;
      else ev[x - k * n] = r - eta;
    end
    for (int x = 0; x < k * k * n; x++) begin
      b.kind = 0; b.idx = x; b.coef = av[x];
      model_q.push_back(b);
    end
    for (int i = 0; i < k; i++)
      for (int d = 0; d < n; d++) begin
        acc = ev[i * n + d];
        for (int j = 0; j < k; j++) begin
          for (int m = 0; m < n; m++) begin
            pa[m] = av[(i * k + j) * n + m];
            ps[m] = sv[j * n + m];
          end
          acc += nc_coef(pa, ps, n, d);
        end
        b.kind = 1; b.idx = i * n + d; b.coef = ((acc % q) + q) % q;
        model_q.push_back(b);
      end
    for (int x = 0; x < k * n; x++) begin
      b.kind = 2; b.idx = x; b.coef = sv[x];
      model_q.push_back(b);
    end
  endtask

  // Ready driver: always ready, or a coin flip per cycle under backpressure.
  initial begin
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready0 = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every accepted beat against the model, stalled beats held stable.
  logic       prev_stall0 = 1'b0;
  logic [23:0] prev_beat0 = '0;
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
      if (prev_stall0) begin
        check_eq("stall_valid_held", valid0, 1);
        check_eq("stall_beat_stable", {kind0, idx0, coef0}, prev_beat0);
      end
      prev_stall0 = valid0 && !out_ready0;
      prev_beat0  = {kind0, idx0, coef0};
      if (valid0 && out_ready0) begin
        if (exp0.size() == 0) begin
          check_eq("dut0_extra_beat", 1, 0);
        end else begin
          b = exp0.pop_front();
          check_eq("dut0_kind", kind0, b.kind);
          check_eq("dut0_idx", idx0, b.idx);
          check_eq("dut0_coef", $signed(coef0), b.coef);
        end
      end
      if (valid1 && out_ready1) begin
        if (exp1.size() == 0) begin
          check_eq("dut1_extra_beat", 1, 0);
        end else begin
          b = exp1.pop_front();
          check_eq("dut1_kind", kind1, b.kind);
          check_eq("dut1_idx", idx1, b.idx);
          check_eq("dut1_coef", $signed(coef1), b.coef);
        end
      end
    end else begin
      prev_stall0 = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    check_eq("dut0_done_within_budget", done0, 1);
    tick();
    check_eq("dut0_done_one_cycle", done0, 0);
    check_eq("dut0_idle_after_done", busy0, 0);
    check_eq("dut0_beats_left", exp0.size(), 0);
    check_eq("dut0_done_pulses", done_cnt0, 1);
  endtask

  task automatic run0(input logic [31:0] model_seed, input logic [31:0] dut_seed, input bit held, input bit bp);
    build_model(2, 4, 17, 1, model_seed);
    exp0 = model_q;
    done_cnt0 = 0;
    bp_mode = bp;
    seed0 = dut_seed;
    start0 = 1'b1;
    tick();
    if (!held) start0 = 1'b0;
    check_eq("dut0_busy_after_start", busy0, 1);
    wait_done0(6000);
    bp_mode = 1'b0;
  endtask

  initial begin
    int_da pa, ps;
    int n, cyc;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    seed0 = 32'd0; seed1 = 32'd0;
    #12;
    // Reset state of both instances.
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_done0", done0, 0);
    check_eq("rst_valid0", valid0, 0);
    check_eq("rst_coef0", coef0, 0);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_valid1", valid1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pin the model with hand-derived values: first two accepted A draws for
    // seed 0xACE1 are 13 and 5; x * x^3 = x^4 = -1 gives 16 mod 17.
    build_model(2, 4, 17, 1, 32'hACE1);
    check_eq("model_beats", model_q.size(), 32);
    check_eq("model_a0", model_q[0].coef, 13);
    check_eq("model_a1", model_q[1].coef, 5);
    pa = new[4]; ps = new[4];
    pa = '{0, 1, 0, 0};
    ps = '{0, 0, 0, 1};
    check_eq("model_negacyclic", ((nc_coef(pa, ps, 4, 0) % 17) + 17) % 17, 16);

    // Known-answer run with the sink always ready.
    run0(32'hACE1, 32'hACE1, 1'b0, 1'b0);
    // Same key under random backpressure, then a second seed under backpressure.
    run0(32'hACE1, 32'hACE1, 1'b0, 1'b1);
    run0(32'h12345678, 32'h12345678, 1'b0, 1'b1);

    // Reset in the middle of the t beats clears every output immediately.
    build_model(2, 4, 17, 1, 32'hACE1);
    exp0 = model_q;
    seed0 = 32'hACE1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (!(valid0 && kind0 == 2'd1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_t_beats", kind0, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy0, 0);
    check_eq("midrst_done", done0, 0);
    check_eq("midrst_valid", valid0, 0);
    check_eq("midrst_kind", kind0, 0);
    check_eq("midrst_idx", idx0, 0);
    check_eq("midrst_coef", coef0, 0);
    exp0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run0(32'hACE1, 32'hACE1, 1'b0, 1'b0);

    // start held high through the run with seed 0: behaves as seed 1, one run only.
    run0(32'h1, 32'h0, 1'b1, 1'b0);

    // Larger configuration: busy-before-stream equals draws plus NV*(NV+1) MAC cycles.
    build_model(3, 8, 3329, 2, 32'hACE1);
    exp1 = model_q;
    done_cnt1 = 0;
    seed1 = 32'hACE1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    cyc = 0;
    while (!valid1 && n < 90000) begin
      @(negedge clk);
      n++;
      if (busy1 && !valid1) cyc++;
    end
    check_eq("dut1_stream_reached", valid1, 1);
    check_eq("dut1_sample_plus_mul_cycles", cyc, model_draws + 600);
    n = 0;
    while (!done1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("dut1_done_within_budget", done1, 1);
    tick();
    check_eq("dut1_beats_left", exp1.size(), 0);
    check_eq("dut1_done_pulses", done_cnt1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
